rca_nibble_sched: RTL and testbench
===================================

# rca_nibble_sched

Multi-cycle add/subtract controller built around the team's 4-bit ripple-carry adder (`RCA`). Two requesters share one `RCA` instance through a round-robin arbiter. The controller then adds or subtracts wide operands one nibble per cycle, registering the carry between nibbles. The result is returned on a valid/ready output port tagged with the winning requester's ID.

## Interface
Parameters:
- `NIBBLES`, default 4: number of nibbles per operand; operand width W = 4*NIBBLES; legal range 1–8.

Ports:
- `clk`  in  1  — single clock; all logic is rising-edge.
- `rst`  in  1  — synchronous, active-high reset.
- `req0_valid`  in  1  — requester 0 holds an operation.
- `req0_ready`  out  1  — requester 0's operation is accepted this cycle.
- `req0_a`, `req0_b`  in  W  — operands (unsigned / two's complement).
- `req0_sub`  in  1  — 0 = a+b, 1 = a−b.
- `req1_valid`, `req1_ready`, `req1_a`, `req1_b`, `req1_sub`  — same as above, for requester 1.
- `res_valid`  out  1  — result available.
- `res_ready`  in  1  — consumer accepts the result.
- `res_sum`  out  W  — result word.
- `res_cout`  out  1  — carry out of MSB; for subtract, 1 = no borrow.
- `res_id`  out  1  — requester that issued the operation.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - If any `reqN_valid` is high, the arbiter grants one requester; that requester's `reqN_ready` is high combinationally in this cycle only.
  - Handshake occurs when valid && ready. On handshake, capture: `a`; `b` (bitwise inverted when `sub`=1); ID; `carry` = `sub`. Clear the nibble index. Go to RUN.
- Arbitration:
  - Round-robin using a `last_grant` register.
  - When both requesters are valid, the one not equal to `last_grant` wins.
  - When only one is valid, it wins regardless of `last_grant`.
  - `last_grant` updates only on handshake.
- RUN:
  - Each cycle, drive `RCA` with nibble[idx] of `a` and `b` and `cin`=`carry`.
  - Store `sum` into result nibble[idx]; `carry` ← `RCA.carry`; idx increments.
  - After nibble NIBBLES−1, go to DONE.
- DONE:
  - `res_valid`=1; `res_sum`, `res_cout` and `res_id` are held stable.
  - On `res_valid && res_ready`, go to IDLE.
- `reqN_ready` is 0 in RUN and DONE. No new operation is accepted until the result has been taken.
- Arithmetic:
  - Subtract is a + ~b + 1, modulo 2^W.
  - `res_cout` is the final registered carry.
  - No overflow flag.

## Timing
- Reset values: `req0_ready`=0, `req1_ready`=0, `res_valid`=0, `res_sum`=0, `res_cout`=0, `res_id`=0. State = IDLE, idx=0, carry=0, `last_grant`=1, so requester 0 wins the first contested cycle.
- Latency: handshake at cycle T; RUN occupies T+1 … T+NIBBLES; `res_valid` rises at T+NIBBLES+1.
- Best-case throughput: one operation per NIBBLES+2 cycles. Result handshake at cycle R allows a new request handshake at R+1 at the earliest.
- `res_ready` low: stay in DONE indefinitely with all outputs stable; requester valids are ignored.
- A requester may drop `valid` before being granted; no state changes.
- Operands are sampled only at handshake. Changes after handshake have no effect.
- `rst` in any state takes effect at the next edge: the operation is aborted, no `res_valid` is produced, and all values return to reset.

## Structure
- Package `rca_sched_pkg`:
  - state enum (IDLE/RUN/DONE);
  - `RCA_W` = 4 constant;
  - requester ID encoding (`REQ0`=0, `REQ1`=1).
- One sub-module: the existing `RCA`, instantiated once with ports `a`, `b`, `cin`, `sum`, `carry`.
- The arbiter stays inline; it is too small to warrant its own module.

## Test plan
- NIBBLES=4. `req0` add 0x0001+0x0001 → `res_sum`=0x0002, `res_cout`=0, `res_id`=0, `res_valid` 5 cycles after handshake.
- `req1` add 0xFFFF+0x0001 → `res_sum`=0x0000, `res_cout`=1 (full carry ripple across all nibbles).
- Subtract 0x0005−0x0007 → 0xFFFE, `res_cout`=0. Subtract 0x8000−0x0000 → 0x8000, `res_cout`=1.
- Both requesters held valid for 4 operations, with `res_ready` tied high → grants 0,1,0,1; each `reqN_ready` is a single-cycle pulse.
- `res_ready` low for 3 cycles in DONE → `res_valid` and data stable; both `reqN_ready`=0; the result is released on the 4th cycle.
- Assert `rst` during RUN (idx=2) → next cycle all outputs are 0 and the state is IDLE; no result emerges; a following `req0` add completes correctly.

Source files
------------

// File: rtl/rca_sched_pkg.sv
// rtl/rca_sched_pkg.sv - shared types and constants for the nibble-serial add/sub scheduler
package rca_sched_pkg;

  localparam int RCA_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic {
    REQ0 = 1'b0,
    REQ1 = 1'b1
  } req_id_t;

endpackage

// File: rtl/rca_nibble_sched_if.sv
// rtl/rca_nibble_sched_if.sv - two request ports and one result port of the scheduler
interface rca_nibble_sched_if #(
  parameter int NIBBLES = 4
);
  localparam int W = 4 * NIBBLES;

  logic         req0_valid;
  logic         req0_ready;
  logic [W-1:0] req0_a;
  logic [W-1:0] req0_b;
  logic         req0_sub;

  logic         req1_valid;
  logic         req1_ready;
  logic [W-1:0] req1_a;
  logic [W-1:0] req1_b;
  logic         req1_sub;

  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] res_sum;
  logic         res_cout;
  logic         res_id;

  modport master (
    output req0_valid, req0_a, req0_b, req0_sub,
    output req1_valid, req1_a, req1_b, req1_sub,
    output res_ready,
    input  req0_ready, req1_ready,
    input  res_valid, res_sum, res_cout, res_id
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_sub,
    input  req1_valid, req1_a, req1_b, req1_sub,
    input  res_ready,
    output req0_ready, req1_ready,
    output res_valid, res_sum, res_cout, res_id
  );

endinterface

// File: rtl/RCA.sv
// rtl/RCA.sv - 4-bit ripple-carry adder
module RCA
  import rca_sched_pkg::*;
(
  input  logic [RCA_W-1:0] a,
  input  logic [RCA_W-1:0] b,
  input  logic             cin,
  output logic [RCA_W-1:0] sum,
  output logic             carry
);

  always_comb begin : ripple
    logic c;
    c   = cin;
    sum = '0;
    for (int i = 0; i < RCA_W; i++) begin
      sum[i] = a[i] ^ b[i] ^ c;
      c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    carry = c;
  end

endmodule

// File: rtl/rca_nibble_sched.sv
// rtl/rca_nibble_sched.sv - round-robin shared RCA doing wide add/sub one nibble per cycle
module rca_nibble_sched
  import rca_sched_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input logic               clk,
  input logic               rst,
  rca_nibble_sched_if.slave bus
);

  localparam int W  = RCA_W * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

  state_t          state_q;
  req_id_t         last_grant_q;
  req_id_t         id_q;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic [W-1:0]    sum_q;
  logic [IW-1:0]   idx_q;
  logic            carry_q;
  logic            res_valid_q;

  logic            grant0;
  logic            grant1;
  logic [W-1:0]    sel_a;
  logic [W-1:0]    sel_b;
  logic            sel_sub;
  logic [RCA_W-1:0] nib_a;
  logic [RCA_W-1:0] nib_b;
  logic [RCA_W-1:0] nib_sum;
  logic            nib_carry;

  // Contested cycles go to whoever was not granted last; a lone requester always wins.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state_q == IDLE) begin
      grant0 = bus.req0_valid && (!bus.req1_valid || (last_grant_q == REQ1));
      grant1 = bus.req1_valid && (!bus.req0_valid || (last_grant_q == REQ0));
    end
  end

  always_comb begin
    sel_a   = grant1 ? bus.req1_a   : bus.req0_a;
    sel_b   = grant1 ? bus.req1_b   : bus.req0_b;
    sel_sub = grant1 ? bus.req1_sub : bus.req0_sub;
  end

  assign nib_a = a_q[RCA_W*int'(idx_q) +: RCA_W];
  assign nib_b = b_q[RCA_W*int'(idx_q) +: RCA_W];

  RCA u_rca (
    .a     (nib_a),
    .b     (nib_b),
    .cin   (carry_q),
    .sum   (nib_sum),
    .carry (nib_carry)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= REQ1;
      id_q         <= REQ0;
      a_q          <= '0;
      b_q          <= '0;
      sum_q        <= '0;
      idx_q        <= '0;
      carry_q      <= 1'b0;
      res_valid_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (grant0 || grant1) begin
            // Subtraction becomes a + ~b with the +1 fed in as the first carry.
            a_q          <= sel_a;
            b_q          <= sel_sub ? ~sel_b : sel_b;
            carry_q      <= sel_sub;
            id_q         <= grant1 ? REQ1 : REQ0;
            last_grant_q <= grant1 ? REQ1 : REQ0;
            idx_q        <= '0;
            state_q      <= RUN;
          end
        end
        RUN: begin
          sum_q[RCA_W*int'(idx_q) +: RCA_W] <= nib_sum;
          carry_q <= nib_carry;
          idx_q   <= idx_q + IW'(1);
          if (idx_q == LAST_IDX) begin
            state_q     <= DONE;
            res_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (bus.res_ready) begin
            res_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;
  assign bus.res_valid  = res_valid_q;
  assign bus.res_sum    = sum_q;
  assign bus.res_cout   = carry_q;
  assign bus.res_id     = id_q;

endmodule

// File: tb/tb_rca_nibble_sched.sv
// tb/tb_rca_nibble_sched.sv - directed bench for rca_nibble_sched with NIBBLES=4
module tb_rca_nibble_sched;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  rca_nibble_sched_if #(.NIBBLES(4)) bus ();

  rca_nibble_sched #(.NIBBLES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic id, input logic [15:0] a, input logic [15:0] b,
                        input logic sub, output int lat);
    int n;
    if (id == 1'b0) begin
      bus.req0_valid = 1'b1; bus.req0_a = a; bus.req0_b = b; bus.req0_sub = sub;
    end else begin
      bus.req1_valid = 1'b1; bus.req1_a = a; bus.req1_b = b; bus.req1_sub = sub;
    end
    #1;
    n = 0;
    while (!(id ? bus.req1_ready : bus.req0_ready) && n < 20) begin
      step();
      n++;
    end
    @(posedge clk);
    #1;
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    bus.req0_a = 16'hDEAD; bus.req0_b = 16'hBEEF; bus.req0_sub = ~sub;
    bus.req1_a = 16'hDEAD; bus.req1_b = 16'hBEEF; bus.req1_sub = ~sub;
    lat = 0;
    while (!bus.res_valid && lat < 30) begin
      step();
      lat++;
    end
    if (n >= 20 || lat >= 30) lat = -1;
  endtask

  task automatic accept();
    bus.res_ready = 1'b1;
    step();
    bus.res_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid: got %b expected 0", bus.res_valid); end
    checks++; if (bus.res_sum !== 16'h0000) begin errors++; $display("FAIL reset_res_sum: got %h expected 0000", bus.res_sum); end
    checks++; if (bus.res_cout !== 1'b0) begin errors++; $display("FAIL reset_res_cout: got %b expected 0", bus.res_cout); end
    checks++; if (bus.res_id !== 1'b0) begin errors++; $display("FAIL reset_res_id: got %b expected 0", bus.res_id); end
    checks++; if (bus.req0_ready !== 1'b0) begin errors++; $display("FAIL reset_req0_ready: got %b expected 0", bus.req0_ready); end
    checks++; if (bus.req1_ready !== 1'b0) begin errors++; $display("FAIL reset_req1_ready: got %b expected 0", bus.req1_ready); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_add_basic();
    int lat;
    run_op(1'b0, 16'h0001, 16'h0001, 1'b0, lat);
    checks++; if (lat !== 4) begin errors++; $display("FAIL add_basic_latency: got %0d edges expected 4", lat); end
    checks++; if (bus.res_sum !== 16'h0002) begin errors++; $display("FAIL add_basic_sum: got %h expected 0002", bus.res_sum); end
    checks++; if (bus.res_cout !== 1'b0) begin errors++; $display("FAIL add_basic_cout: got %b expected 0", bus.res_cout); end
    checks++; if (bus.res_id !== 1'b0) begin errors++; $display("FAIL add_basic_id: got %b expected 0", bus.res_id); end
    accept();
    checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL add_basic_release: got %b expected 0", bus.res_valid); end
  endtask

  task automatic test_add_carry();
    int lat;
    run_op(1'b1, 16'hFFFF, 16'h0001, 1'b0, lat);
    checks++; if (lat !== 4) begin errors++; $display("FAIL carry_latency: got %0d expected 4", lat); end
    checks++; if (bus.res_sum !== 16'h0000) begin errors++; $display("FAIL carry_sum: got %h expected 0000", bus.res_sum); end
    checks++; if (bus.res_cout !== 1'b1) begin errors++; $display("FAIL carry_cout: got %b expected 1", bus.res_cout); end
    checks++; if (bus.res_id !== 1'b1) begin errors++; $display("FAIL carry_id: got %b expected 1", bus.res_id); end
    accept();
  endtask

  task automatic test_sub();
    int lat;
    run_op(1'b0, 16'h0005, 16'h0007, 1'b1, lat);
    checks++; if (lat !== 4) begin errors++; $display("FAIL sub_neg_latency: got %0d expected 4", lat); end
    checks++; if (bus.res_sum !== 16'hFFFE) begin errors++; $display("FAIL sub_neg_sum: got %h expected fffe", bus.res_sum); end
    checks++; if (bus.res_cout !== 1'b0) begin errors++; $display("FAIL sub_neg_cout: got %b expected 0", bus.res_cout); end
    accept();
    run_op(1'b0, 16'h8000, 16'h0000, 1'b1, lat);
    checks++; if (bus.res_sum !== 16'h8000) begin errors++; $display("FAIL sub_zero_sum: got %h expected 8000", bus.res_sum); end
    checks++; if (bus.res_cout !== 1'b1) begin errors++; $display("FAIL sub_zero_cout: got %b expected 1", bus.res_cout); end
    accept();
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_grants;
    int ng, nr, last_cyc;
    logic prev_rdy, g;
    exp_grants = 4'b1010;
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.res_ready = 1'b1;
    bus.req0_valid = 1'b1; bus.req0_a = 16'h1000; bus.req0_b = 16'h0234; bus.req0_sub = 1'b0;
    bus.req1_valid = 1'b1; bus.req1_a = 16'h0100; bus.req1_b = 16'h0001; bus.req1_sub = 1'b1;
    #1;
    ng = 0; nr = 0; last_cyc = -1; prev_rdy = 1'b0;
    for (int cyc = 0; cyc < 60 && nr < 4; cyc++) begin
      if (ng >= 4) begin
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
      end
      if (bus.req0_ready || bus.req1_ready) begin
        g = bus.req1_ready;
        checks++;
        if (ng >= 4) begin
          errors++; $display("FAIL b2b_extra_grant: got grant %b at cycle %0d expected none", g, cyc);
        end else if ((bus.req0_ready && bus.req1_ready) || g !== exp_grants[ng]) begin
          errors++; $display("FAIL b2b_grant_%0d: got ready0=%b ready1=%b expected id %b", ng, bus.req0_ready, bus.req1_ready, exp_grants[ng]);
        end
        checks++; if (prev_rdy) begin errors++; $display("FAIL b2b_pulse: got ready high two cycles running at %0d expected single pulse", cyc); end
        if (last_cyc >= 0) begin
          checks++; if (cyc - last_cyc != 6) begin errors++; $display("FAIL b2b_spacing: got %0d cycles expected 6", cyc - last_cyc); end
        end
        last_cyc = cyc;
        ng++;
      end
      prev_rdy = bus.req0_ready || bus.req1_ready;
      if (bus.res_valid) begin
        checks++;
        if (bus.res_id !== exp_grants[nr]) begin
          errors++; $display("FAIL b2b_res_id_%0d: got %b expected %b", nr, bus.res_id, exp_grants[nr]);
        end
        checks++;
        if (exp_grants[nr] ? (bus.res_sum !== 16'h00FF || bus.res_cout !== 1'b1)
                           : (bus.res_sum !== 16'h1234 || bus.res_cout !== 1'b0)) begin
          errors++; $display("FAIL b2b_res_%0d: got %h/%b expected %s", nr, bus.res_sum, bus.res_cout, exp_grants[nr] ? "00ff/1" : "1234/0");
        end
        nr++;
      end
      step();
    end
    checks++; if (nr != 4) begin errors++; $display("FAIL b2b_count: got %0d results expected 4", nr); end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.res_ready  = 1'b0;
    step();
  endtask

  task automatic test_backpressure();
    int lat;
    run_op(1'b1, 16'h1234, 16'h1111, 1'b0, lat);
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    bus.req0_sub = 1'b0; bus.req1_sub = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bus.res_valid !== 1'b1 || bus.res_sum !== 16'h2345 || bus.res_cout !== 1'b0 || bus.res_id !== 1'b1) begin
        errors++; $display("FAIL hold_%0d: got v=%b sum=%h c=%b id=%b expected 1/2345/0/1", i, bus.res_valid, bus.res_sum, bus.res_cout, bus.res_id);
      end
      checks++;
      if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin
        errors++; $display("FAIL hold_ready_%0d: got %b%b expected 00", i, bus.req0_ready, bus.req1_ready);
      end
      step();
    end
    bus.res_ready = 1'b1;
    #1;
    checks++; if (bus.res_valid !== 1'b1) begin errors++; $display("FAIL hold_release_valid: got %b expected 1", bus.res_valid); end
    step();
    bus.res_ready = 1'b0;
    checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL hold_after_release: got %b expected 0", bus.res_valid); end
    checks++;
    if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin
      errors++; $display("FAIL hold_next_grant: got %b%b expected ready0 only", bus.req0_ready, bus.req1_ready);
    end
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    step();
    checks++;
    if (bus.res_valid !== 1'b0 || bus.req0_ready !== 1'b0 || bus.res_sum !== 16'h2345) begin
      errors++; $display("FAIL withdraw: got v=%b r0=%b sum=%h expected 0/0/2345", bus.res_valid, bus.req0_ready, bus.res_sum);
    end
  endtask

  task automatic test_reset_mid_run();
    int lat;
    int seen;
    bus.req1_valid = 1'b1; bus.req1_a = 16'h0003; bus.req1_b = 16'h0001; bus.req1_sub = 1'b1;
    @(posedge clk);
    #1;
    bus.req1_valid = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid: got %b expected 0", bus.res_valid); end
    checks++; if (bus.res_sum !== 16'h0000) begin errors++; $display("FAIL mid_rst_sum: got %h expected 0000", bus.res_sum); end
    checks++; if (bus.res_cout !== 1'b0) begin errors++; $display("FAIL mid_rst_cout: got %b expected 0", bus.res_cout); end
    checks++; if (bus.res_id !== 1'b0) begin errors++; $display("FAIL mid_rst_id: got %b expected 0", bus.res_id); end
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.res_valid) seen++;
      step();
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL mid_rst_no_result: got %0d valid cycles expected 0", seen); end
    run_op(1'b0, 16'h0F0F, 16'h0101, 1'b0, lat);
    checks++; if (lat !== 4) begin errors++; $display("FAIL post_rst_latency: got %0d expected 4", lat); end
    checks++;
    if (bus.res_sum !== 16'h1010 || bus.res_cout !== 1'b0 || bus.res_id !== 1'b0) begin
      errors++; $display("FAIL post_rst_result: got %h/%b/%b expected 1010/0/0", bus.res_sum, bus.res_cout, bus.res_id);
    end
    accept();
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_sub = 1'b0;
    bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_sub = 1'b0;
    bus.res_ready  = 1'b0;
    test_reset();
    test_add_basic();
    test_add_carry();
    test_sub();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
